// File: rtl/sail_print_stream.sv
// sail_print_stream: round-robin print arbiter, byte serialiser and output byte FIFO.
// Latency: request accepted at edge t -> first byte in FIFO / on out_char after edge t+1.
// Backpressure: serialiser stalls in EMIT/NEWLINE while the FIFO is full; FIFO drains on in_char_ready.
module sail_print_stream #(
  parameter int CHANNELS = 2,
  parameter int MAX_LEN  = 32,
  parameter int DEPTH    = 16,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic [CHANNELS-1:0]           in_req_valid,
  input  logic [CHANNELS*MAX_LEN*8-1:0] in_req_data,
  input  logic [CHANNELS*LW-1:0]        in_req_len,
  input  logic [CHANNELS-1:0]           in_req_endline,
  output logic [CHANNELS-1:0]           out_req_ready,
  output logic [CHANNELS-1:0]           out_done,
  output logic [7:0]                    out_char,
  output logic                          out_char_valid,
  input  logic                          in_char_ready,
  output logic [CW-1:0]                 out_fifo_count,
  output logic                          out_busy
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = MAX_LEN * 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EMIT    = 2'd1;
  localparam logic [1:0] S_NEWLINE = 2'd2;

  // serialiser state
  logic [1:0]          r_state;
  logic [CHW-1:0]      r_rr;
  logic [CHW-1:0]      r_ch;
  logic [DW-1:0]       r_data;
  logic [LW-1:0]       r_len;
  logic                r_endl;
  logic [LW-1:0]       r_idx;
  logic [CHANNELS-1:0] r_done;

  // output FIFO
  logic [7:0]          r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;

  logic                w_gnt_vld;
  logic [CHW-1:0]      w_gnt_ch;
  logic [DW-1:0]       w_data_sel;
  logic [LW-1:0]       w_len_sel;
  logic [LW-1:0]       w_len_clamp;
  logic                w_endl_sel;
  logic [7:0]          w_cur_byte;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic [7:0]          w_push_dat;
  logic [1:0]          w_state_nx;
  logic [LW-1:0]       w_idx_nx;
  logic                w_done_fire;
  logic                w_accept;

  // Round-robin search: scan from the highest offset down so the lowest offset from r_rr wins.
  always_comb begin
    int c;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    c         = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      c = (int'(r_rr) + k) % CHANNELS;
      if (|(in_req_valid & (CHANNELS'(1) << c))) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CHW'(c);
      end
    end
  end

  assign w_data_sel  = DW'(in_req_data >> (int'(w_gnt_ch) * DW));
  assign w_len_sel   = LW'(in_req_len >> (int'(w_gnt_ch) * LW));
  assign w_len_clamp = (w_len_sel > LW'(MAX_LEN)) ? LW'(MAX_LEN) : w_len_sel;
  assign w_endl_sel  = |(in_req_endline & (CHANNELS'(1) << w_gnt_ch));
  assign w_cur_byte  = 8'(r_data >> {r_idx, 3'b000});

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && in_char_ready;

  // Next-state logic; the last message byte finishes the message on its own push edge.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_push      = 1'b0;
    w_push_dat  = 8'h00;
    w_done_fire = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_accept   = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_idx < r_len) begin
          if (!w_full) begin
            w_push     = 1'b1;
            w_push_dat = w_cur_byte;
            w_idx_nx   = r_idx + LW'(1);
            if (r_idx + LW'(1) == r_len) begin
              if (r_endl) begin
                w_state_nx = S_NEWLINE;
              end else begin
                w_done_fire = 1'b1;
                w_state_nx  = S_IDLE;
              end
            end
          end
        end else if (r_endl) begin
          w_state_nx = S_NEWLINE;
        end else begin
          w_done_fire = 1'b1;
          w_state_nx  = S_IDLE;
        end
      end
      S_NEWLINE: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_dat  = 8'h0A;
          w_done_fire = 1'b1;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Serialiser registers; a message in flight at reset is dropped without a done pulse.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_ch    <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_endl  <= 1'b0;
      r_idx   <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_done  <= w_done_fire ? (CHANNELS'(1) << r_ch) : '0;
      if (w_accept) begin
        r_data <= w_data_sel;
        r_len  <= w_len_clamp;
        r_endl <= w_endl_sel;
        r_ch   <= w_gnt_ch;
        r_rr   <= CHW'((int'(w_gnt_ch) + 1) % CHANNELS);
      end
    end
  end

  // FIFO storage has no reset; r_count gates every read of it.
  always_ff @(posedge in_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_dat;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_req_ready  = (!in_reset && (r_state == S_IDLE) && w_gnt_vld) ?
                          (CHANNELS'(1) << w_gnt_ch) : '0;
  assign out_done       = r_done;
  assign out_char_valid = (r_count != '0);
  assign out_char       = out_char_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign out_fifo_count = r_count;
  assign out_busy       = (r_state != S_IDLE) || out_char_valid;

endmodule

// File: tb/tb_sail_print_stream.sv
// Bench for sail_print_stream: table-driven messages, arbitration/backpressure/reset
// sequences, then randomized traffic checked by a queue-based output scoreboard.
module tb_sail_print_stream;
  localparam int CH = 2;
  localparam int ML = 32;
  localparam int DP = 16;
  localparam int LW = $clog2(ML + 1);
  localparam int CW = $clog2(DP + 1);
  localparam int NRAND = 30;

  logic                 in_clk;
  logic                 in_reset;
  logic [CH-1:0]        in_req_valid;
  logic [CH*ML*8-1:0]   in_req_data;
  logic [CH*LW-1:0]     in_req_len;
  logic [CH-1:0]        in_req_endline;
  logic [CH-1:0]        out_req_ready;
  logic [CH-1:0]        out_done;
  logic [7:0]           out_char;
  logic                 out_char_valid;
  logic                 in_char_ready;
  logic [CW-1:0]        out_fifo_count;
  logic                 out_busy;

  // bench-side request registers per channel
  logic [ML*8-1:0] drv_data [CH];
  logic [LW-1:0]   drv_len  [CH];
  logic            drv_endl [CH];
  logic            drv_vld  [CH];
  bit              acc_pend [CH];

  assign in_req_data    = {drv_data[1], drv_data[0]};
  assign in_req_len     = {drv_len[1], drv_len[0]};
  assign in_req_endline = {drv_endl[1], drv_endl[0]};
  assign in_req_valid   = {drv_vld[1], drv_vld[0]};

  sail_print_stream #(.CHANNELS(CH), .MAX_LEN(ML), .DEPTH(DP)) dut (
    .in_clk         (in_clk),
    .in_reset       (in_reset),
    .in_req_valid   (in_req_valid),
    .in_req_data    (in_req_data),
    .in_req_len     (in_req_len),
    .in_req_endline (in_req_endline),
    .out_req_ready  (out_req_ready),
    .out_done       (out_done),
    .out_char       (out_char),
    .out_char_valid (out_char_valid),
    .in_char_ready  (in_char_ready),
    .out_fifo_count (out_fifo_count),
    .out_busy       (out_busy)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc_cnt = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  always @(posedge in_clk) cyc_cnt <= cyc_cnt + 1;

  // reference model state
  logic [7:0] exp_q[$];
  int         exp_done_q[$];
  logic [7:0] cap_q[$];
  int         grant_q[$];
  int         m_rr = 0;
  int         done_cnt [CH];
  int         done_cyc [CH];
  int         acc_edge [CH];
  int         n_acc_tot = 0;
  int         n_done_tot = 0;

  function automatic int pred_grant(input logic [CH-1:0] v, input int rr);
    for (int k = 0; k < CH; k++)
      if (v[(rr + k) % CH]) return (rr + k) % CH;
    return -1;
  endfunction

  // Scoreboard: predict grants and byte stream, compare every popped byte and done pulse.
  always @(negedge in_clk) begin
    logic [CH-1:0] acc;
    logic [CH-1:0] exp_oh;
    logic [7:0]    e;
    int            p, n, ed;
    if (in_reset) begin
      exp_q.delete();
      exp_done_q.delete();
      m_rr = 0;
    end else begin
      if (out_char_valid && in_char_ready) begin
        cap_q.push_back(out_char);
        check(exp_q.size() > 0, "byte_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check(out_char == e, "stream_byte", int'(out_char), int'(e));
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (out_done[c]) begin
          done_cnt[c]++;
          done_cyc[c] = cyc_cnt;
          n_done_tot++;
          check(exp_done_q.size() > 0, "done_pending", c, 1);
          if (exp_done_q.size() > 0) begin
            ed = exp_done_q.pop_front();
            check(ed == c, "done_channel", c, ed);
          end
        end
      end
      acc = in_req_valid & out_req_ready;
      if (acc != '0) begin
        p = pred_grant(in_req_valid, m_rr);
        exp_oh = '0;
        if (p >= 0) exp_oh[p] = 1'b1;
        check(acc == exp_oh, "grant", int'(acc), int'(exp_oh));
        for (int c = 0; c < CH; c++) if (acc[c]) acc_pend[c] = 1'b1;
        if (p >= 0) begin
          n_acc_tot++;
          m_rr = (p + 1) % CH;
          grant_q.push_back(p);
          acc_edge[p] = cyc_cnt + 1;
          n = (int'(drv_len[p]) > ML) ? ML : int'(drv_len[p]);
          for (int i = 0; i < n; i++) exp_q.push_back(8'(drv_data[p] >> (i * 8)));
          if (drv_endl[p]) exp_q.push_back(8'h0A);
          exp_done_q.push_back(p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
    for (int c = 0; c < CH; c++)
      if (acc_pend[c]) begin
        drv_vld[c]  = 1'b0;
        acc_pend[c] = 1'b0;
      end
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    tick();
    tick();
    in_reset = 1'b0;
    tick();
  endtask

  function automatic logic [ML*8-1:0] mk_seq();
    logic [ML*8-1:0] d;
    for (int i = 0; i < ML; i++) d[i*8 +: 8] = 8'(8'h30 + i);
    return d;
  endfunction

  function automatic logic [ML*8-1:0] mk2(input logic [7:0] b0, input logic [7:0] b1);
    logic [ML*8-1:0] d;
    d = '0;
    d[7:0]  = b0;
    d[15:8] = b1;
    return d;
  endfunction

  typedef struct {
    int              ch;
    int              len;
    bit              endl;
    logic [ML*8-1:0] data;
    int              exp_n;
    logic [7:0]      exp_first;
    logic [7:0]      exp_last;
    int              exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic load(input int c, input int len, input bit endl, input logic [ML*8-1:0] d);
    drv_data[c] = d;
    drv_len[c]  = LW'(len);
    drv_endl[c] = endl;
    drv_vld[c]  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int d0, t;
    cap_q.delete();
    d0 = done_cnt[v.ch];
    load(v.ch, v.len, v.endl, v.data);
    t = 0;
    while ((done_cnt[v.ch] == d0 || out_busy) && t < 300) begin
      tick();
      t++;
    end
    check(t < 300, "vec_timeout", t, 300);
    tick();
    tick();
    check(cap_q.size() == v.exp_n, "vec_nbytes", cap_q.size(), v.exp_n);
    if (v.exp_n > 0 && cap_q.size() > 0) begin
      check(cap_q[0] == v.exp_first, "vec_first", int'(cap_q[0]), int'(v.exp_first));
      check(cap_q[$] == v.exp_last, "vec_last", int'(cap_q[$]), int'(v.exp_last));
    end
    check(done_cnt[v.ch] - d0 == 1, "vec_done_count", done_cnt[v.ch] - d0, 1);
    check(done_cyc[v.ch] - acc_edge[v.ch] == v.exp_lat, "vec_done_latency",
          done_cyc[v.ch] - acc_edge[v.ch], v.exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish", cyc_cnt);
    $fatal(1);
  end

  initial begin
    int t, d0, loads, sent, a0, dn0;
    bit fin;

    vecs[0] = '{0, 2,  1'b0, mk2(8'h48, 8'h69), 2,  8'h48, 8'h69, 2};
    vecs[1] = '{1, 2,  1'b1, mk2(8'h6F, 8'h6B), 3,  8'h6F, 8'h0A, 3};
    vecs[2] = '{0, 0,  1'b1, mk_seq(),          1,  8'h0A, 8'h0A, 2};
    vecs[3] = '{1, 0,  1'b0, mk_seq(),          0,  8'h00, 8'h00, 1};
    vecs[4] = '{0, 37, 1'b0, mk_seq(),          32, 8'h30, 8'h4F, 32};
    vecs[5] = '{1, 32, 1'b1, mk_seq(),          33, 8'h30, 8'h0A, 33};
    vecs[6] = '{0, 1,  1'b0, mk_seq(),          1,  8'h30, 8'h30, 1};

    for (int c = 0; c < CH; c++) begin
      drv_data[c] = '0;
      drv_len[c]  = '0;
      drv_endl[c] = 1'b0;
      drv_vld[c]  = 1'b0;
      acc_pend[c] = 1'b0;
      done_cnt[c] = 0;
      done_cyc[c] = 0;
      acc_edge[c] = 0;
    end
    in_reset = 1'b1;
    in_char_ready = 1'b1;

    // reset state
    tick();
    tick();
    check(out_req_ready == '0, "rst_req_ready", int'(out_req_ready), 0);
    check(out_done == '0, "rst_done", int'(out_done), 0);
    check(out_char_valid == 1'b0, "rst_char_valid", int'(out_char_valid), 0);
    check(out_char == 8'h00, "rst_char", int'(out_char), 0);
    check(out_fifo_count == '0, "rst_fifo_count", int'(out_fifo_count), 0);
    check(out_busy == 1'b0, "rst_busy", int'(out_busy), 0);
    in_reset = 1'b0;
    tick();

    // table-driven messages with the sink always ready
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // both channels continuously requesting: grants alternate from ch0
    do_reset();
    grant_q.delete();
    load(0, 1, 1'b0, mk_seq());
    load(1, 1, 1'b0, mk_seq());
    loads = 2;
    t = 0;
    while ((loads < 6 || drv_vld[0] || drv_vld[1] || out_busy) && t < 200) begin
      tick();
      t++;
      for (int c = 0; c < CH; c++)
        if (!drv_vld[c] && loads < 6) begin
          load(c, 1, 1'b0, mk_seq());
          loads++;
        end
    end
    check(t < 200, "rr_timeout", t, 200);
    check(grant_q.size() == 6, "rr_grant_count", grant_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check(grant_q[i] == i % 2, "rr_grant_order", grant_q[i], i % 2);

    // FIFO saturation with a stalled sink, then drain
    cap_q.delete();
    in_char_ready = 1'b0;
    d0 = done_cnt[0];
    load(0, 20, 1'b0, mk_seq());
    for (int i = 0; i < 40; i++) tick();
    check(out_fifo_count == CW'(DP), "full_count", int'(out_fifo_count), DP);
    check(out_busy == 1'b1, "full_busy", int'(out_busy), 1);
    check(out_char == 8'h30, "full_head", int'(out_char), 8'h30);
    check(done_cnt[0] == d0, "full_no_done", done_cnt[0] - d0, 0);
    in_char_ready = 1'b1;
    t = 0;
    while ((done_cnt[0] == d0 || out_busy) && t < 200) begin
      tick();
      t++;
    end
    check(t < 200, "drain_timeout", t, 200);
    check(cap_q.size() == 20, "drain_nbytes", cap_q.size(), 20);
    for (int i = 0; i < 20 && i < cap_q.size(); i++)
      check(cap_q[i] == 8'(8'h30 + i), "drain_byte", int'(cap_q[i]), 8'h30 + i);

    // reset in the middle of a message
    d0 = done_cnt[0];
    load(0, 20, 1'b0, mk_seq());
    t = 0;
    while (!out_busy && t < 50) begin
      tick();
      t++;
    end
    tick();
    tick();
    tick();
    #3;
    in_reset = 1'b1;
    load(1, 1, 1'b0, mk_seq());
    #1;
    check(out_req_ready == '0, "arst_req_ready", int'(out_req_ready), 0);
    check(out_done == '0, "arst_done", int'(out_done), 0);
    check(out_char_valid == 1'b0, "arst_char_valid", int'(out_char_valid), 0);
    check(out_char == 8'h00, "arst_char", int'(out_char), 0);
    check(out_fifo_count == '0, "arst_fifo_count", int'(out_fifo_count), 0);
    check(out_busy == 1'b0, "arst_busy", int'(out_busy), 0);
    drv_vld[1] = 1'b0;
    tick();
    tick();
    in_reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check(done_cnt[0] == d0, "arst_no_done", done_cnt[0] - d0, 0);
    run_vec(vecs[0]);

    // randomized traffic with a random sink
    a0 = n_acc_tot;
    dn0 = n_done_tot;
    sent = 0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      tick();
      in_char_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++)
        if (!drv_vld[c] && sent < NRAND && $urandom_range(0, 2) == 0) begin
          for (int w = 0; w < ML / 4; w++) drv_data[c][w*32 +: 32] = $urandom();
          drv_len[c]  = LW'($urandom_range(0, ML + 6));
          drv_endl[c] = 1'($urandom_range(0, 1));
          drv_vld[c]  = 1'b1;
          sent++;
        end
      if (sent == NRAND && !drv_vld[0] && !drv_vld[1] && !out_busy &&
          exp_q.size() == 0 && exp_done_q.size() == 0)
        fin = 1'b1;
    end
    in_char_ready = 1'b1;
    check(fin, "rand_complete", int'(fin), 1);
    check(exp_q.size() == 0, "rand_bytes_left", exp_q.size(), 0);
    check(exp_done_q.size() == 0, "rand_dones_left", exp_done_q.size(), 0);
    check(n_acc_tot - a0 == NRAND, "rand_accepts", n_acc_tot - a0, NRAND);
    check(n_done_tot - dn0 == NRAND, "rand_dones", n_done_tot - dn0, NRAND);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
